// File: rtl/spart_pkg.sv
// Shared constants for the SPART bus responder: register addresses,
// status bit positions, serial FSM encodings and the baud reload helper.
package spart_pkg;

    localparam int OVERSAMPLE_DEF = 16;

    localparam logic [1:0] ADDR_DATA = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    localparam int STAT_TBR = 0;
    localparam int STAT_RDA = 1;
    localparam int STAT_OE  = 2;
    localparam int STAT_FE  = 3;

    // Shared by the TX and RX state machines
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // A divisor of zero behaves like one: a tick every cycle
    function automatic logic [15:0] baud_reload(input logic [15:0] db);
        return (db == 16'd0) ? 16'd0 : db - 16'd1;
    endfunction

endpackage

// File: rtl/spart_rx.sv
// 8N1 receiver: two-flop synchroniser, start-bit qualification at mid-bit,
// mid-bit data/stop sampling; reports each frame with a one-cycle rx_done.
module spart_rx
    import spart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       tick,
    output logic       rx_done,
    output logic [7:0] rx_data,
    output logic       rx_ferr
);

    localparam int            TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);

    logic          meta_q, sync_q, prev_q;
    logic [1:0]    state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          done_q, done_d;
    logic          ferr_q, ferr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rxd;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // Once the start bit is confirmed at mid-bit, each later sample lands a
    // full bit period on, i.e. at the middle of every data and stop bit.
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
        case (state_q)
            ST_IDLE: begin
                if (prev_q && !sync_q) begin
                    state_d = ST_START;
                    tcnt_d  = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (tcnt_q == TICK_MID) begin
                        tcnt_d  = '0;
                        bcnt_d  = '0;
                        state_d = sync_q ? ST_IDLE : ST_DATA;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (tcnt_q == TICK_LAST) begin
                        tcnt_d  = '0;
                        shift_d = {sync_q, shift_q[7:1]};
                        if (bcnt_q == 3'd7) state_d = ST_STOP;
                        else                bcnt_d  = bcnt_q + 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (tcnt_q == TICK_LAST) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        ferr_d  = ~sync_q;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign rx_done = done_q;
    assign rx_data = shift_q;
    assign rx_ferr = ferr_q;

endmodule

// File: rtl/spart_responder.sv
// SPART bus responder: register decode, baud divisor and tick generator,
// 8N1 transmitter, and the status/receive buffer fed by spart_rx.
module spart_responder
    import spart_pkg::*;
#(
    parameter int          OVERSAMPLE = OVERSAMPLE_DEF,
    parameter logic [15:0] DB_RESET   = 16'h0516
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       tbr,
    output logic       rda,
    output logic       txd,
    input  logic       rxd
);

    localparam int            TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

    logic          rd_en, wr_en, wr_data, rd_data, rd_stat, db_wr;
    logic [7:0]    rd_mux, status;
    logic [15:0]   db_q, db_d, baud_q, baud_d;
    logic          tick;
    logic [1:0]    tx_state_q, tx_state_d;
    logic [TW-1:0] tx_tcnt_q, tx_tcnt_d;
    logic [2:0]    tx_bcnt_q, tx_bcnt_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tbr_q, tbr_d, txd_q, txd_d;
    logic          rda_q, rda_d, oe_q, oe_d, fe_q, fe_d;
    logic [7:0]    rx_buf_q, rx_buf_d;
    logic          rx_done, rx_ferr;
    logic [7:0]    rx_data;

    assign rd_en   = iocs & iorw;
    assign wr_en   = iocs & ~iorw;
    assign wr_data = wr_en && (ioaddr == ADDR_DATA);
    assign rd_data = rd_en && (ioaddr == ADDR_DATA);
    assign rd_stat = rd_en && (ioaddr == ADDR_STAT);
    assign db_wr   = wr_en && (ioaddr == ADDR_DBL || ioaddr == ADDR_DBH);

    always_comb begin
        status           = '0;
        status[STAT_TBR] = tbr_q;
        status[STAT_RDA] = rda_q;
        status[STAT_OE]  = oe_q;
        status[STAT_FE]  = fe_q;
        case (ioaddr)
            ADDR_DATA: rd_mux = rx_buf_q;
            ADDR_STAT: rd_mux = status;
            ADDR_DBL:  rd_mux = db_q[7:0];
            ADDR_DBH:  rd_mux = db_q[15:8];
        endcase
    end

    assign databus = rd_en ? rd_mux : 8'hzz;

    // A divisor write restarts the count from the new value on the same edge
    always_comb begin
        db_d = db_q;
        if (wr_en && ioaddr == ADDR_DBL) db_d[7:0]  = databus;
        if (wr_en && ioaddr == ADDR_DBH) db_d[15:8] = databus;
        baud_d = (db_wr || baud_q == 16'd0) ? baud_reload(db_d) : baud_q - 16'd1;
    end

    assign tick = (baud_q == 16'd0);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tcnt_d  = tx_tcnt_q;
        tx_bcnt_d  = tx_bcnt_q;
        tx_shift_d = tx_shift_q;
        tbr_d      = tbr_q;
        case (tx_state_q)
            ST_IDLE: begin
                if (wr_data && tbr_q) begin
                    tx_shift_d = databus;
                    tx_tcnt_d  = '0;
                    tx_bcnt_d  = '0;
                    tbr_d      = 1'b0;
                    tx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (tx_tcnt_q == TICK_LAST) begin
                        tx_tcnt_d  = '0;
                        tx_state_d = ST_DATA;
                    end else begin
                        tx_tcnt_d = tx_tcnt_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (tx_tcnt_q == TICK_LAST) begin
                        tx_tcnt_d  = '0;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        if (tx_bcnt_q == 3'd7) tx_state_d = ST_STOP;
                        else                   tx_bcnt_d  = tx_bcnt_q + 1'b1;
                    end else begin
                        tx_tcnt_d = tx_tcnt_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (tx_tcnt_q == TICK_LAST) begin
                        tx_state_d = ST_IDLE;
                        tbr_d      = 1'b1;
                    end else begin
                        tx_tcnt_d = tx_tcnt_q + 1'b1;
                    end
                end
            end
        endcase
        txd_d = (tx_state_d == ST_START) ? 1'b0 :
                (tx_state_d == ST_DATA)  ? tx_shift_d[0] : 1'b1;
    end

    // Reading data in the same cycle a new frame lands is not an overrun
    always_comb begin
        rda_d    = rda_q;
        oe_d     = oe_q;
        fe_d     = fe_q;
        rx_buf_d = rx_buf_q;
        if (rd_data) rda_d = 1'b0;
        if (rd_stat) begin
            oe_d = 1'b0;
            fe_d = 1'b0;
        end
        if (rx_done) begin
            if (rx_ferr) begin
                fe_d = 1'b1;
            end else begin
                rx_buf_d = rx_data;
                rda_d    = 1'b1;
                if (rda_q && !rd_data) oe_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_q       <= DB_RESET;
            baud_q     <= baud_reload(DB_RESET);
            tx_state_q <= ST_IDLE;
            tx_tcnt_q  <= '0;
            tx_bcnt_q  <= '0;
            tbr_q      <= 1'b1;
            txd_q      <= 1'b1;
            rda_q      <= 1'b0;
            oe_q       <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            db_q       <= db_d;
            baud_q     <= baud_d;
            tx_state_q <= tx_state_d;
            tx_tcnt_q  <= tx_tcnt_d;
            tx_bcnt_q  <= tx_bcnt_d;
            tbr_q      <= tbr_d;
            txd_q      <= txd_d;
            rda_q      <= rda_d;
            oe_q       <= oe_d;
            fe_q       <= fe_d;
        end
    end

    always_ff @(posedge clk) begin
        tx_shift_q <= tx_shift_d;
        rx_buf_q   <= rx_buf_d;
    end

    spart_rx #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_rx (
        .clk    (clk),
        .rst    (rst),
        .rxd    (rxd),
        .tick   (tick),
        .rx_done(rx_done),
        .rx_data(rx_data),
        .rx_ferr(rx_ferr)
    );

    assign tbr = tbr_q;
    assign rda = rda_q;
    assign txd = txd_q;

endmodule

// File: tb/tb_spart_responder.sv
// Scoreboard bench for spart_responder: bus reads, TX bit timing, loopback
// receive, overrun, framing error, glitch rejection and reset mid-frame.
module tb_spart_responder;
    import spart_pkg::*;

    logic       clk = 1'b0;
    logic       rst, iocs, iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic       drv_en;
    logic [7:0] drv_val;
    logic       tbr, rda, txd;
    logic       rxd_drv, loop;
    wire        rxd_w = loop ? txd : rxd_drv;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;

    logic [7:0] rd_q[$];
    logic       tx_q[$];
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign databus = drv_en ? drv_val : 8'hzz;

    spart_responder #(
        .OVERSAMPLE(16),
        .DB_RESET  (16'h0516)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .iocs   (iocs),
        .iorw   (iorw),
        .ioaddr (ioaddr),
        .databus(databus),
        .tbr    (tbr),
        .rda    (rda),
        .txd    (txd),
        .rxd    (rxd_w)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; drv_en = 1'b1; drv_val = d;
        @(negedge clk);
        iocs = 1'b0; drv_en = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        #1 d = databus;
        @(negedge clk);
        iocs = 1'b0; iorw = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] d;
        rd_q.push_back(exp);
        bus_rd(a, d);
        chk(tag, d, rd_q.pop_front());
    endtask

    task automatic push_tx(input logic [7:0] b);
        for (int i = 0; i < 8; i++) tx_q.push_back(b[i]);
        tx_q.push_back(1'b1);
    endtask

    task automatic wait_tbr(input int lim);
        int n = 0;
        while (tbr !== 1'b1 && n < lim) begin @(negedge clk); n++; end
        chk("tbr_wait", tbr, 1'b1);
    endtask

    task automatic wait_rda(input int lim);
        int n = 0;
        while (rda !== 1'b1 && n < lim) begin @(negedge clk); n++; end
        chk("rda_wait", rda, 1'b1);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        rxd_drv = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            repeat (64) @(negedge clk);
        end
        rxd_drv = stop;
        repeat (64) @(negedge clk);
        rxd_drv = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, n, hi;
        logic [7:0] d;
        rst = 1'b1; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
        drv_en = 1'b0; drv_val = 8'h00; rxd_drv = 1'b1; loop = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tbr", tbr, 1'b1);
        chk("rst_rda", rda, 1'b0);
        chk("rst_txd", txd, 1'b1);

        // Bus must float when not being read
        drv_en = 1'b1; drv_val = 8'hA5;
        #1 chk("bus_float_idle", databus, 8'hA5);
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b0; ioaddr = ADDR_STAT; drv_val = 8'h5A;
        #1 chk("bus_float_wr", databus, 8'h5A);
        @(negedge clk);
        iocs = 1'b0; drv_en = 1'b0;
        rd_chk("rst_dbl", ADDR_DBL, 8'h16);
        rd_chk("rst_dbh", ADDR_DBH, 8'h05);
        rd_chk("rst_stat", ADDR_STAT, 8'h01);

        bus_wr(ADDR_DBL, 8'h04);
        bus_wr(ADDR_DBH, 8'h00);
        rd_chk("db_lo", ADDR_DBL, 8'h04);
        rd_chk("db_hi", ADDR_DBH, 8'h00);

        // Transmit 0x55 and check every bit at mid-bit
        push_tx(8'h55);
        bus_wr(ADDR_DATA, 8'h55);
        t0 = cyc;
        chk("tx_tbr_low", tbr, 1'b0);
        chk("tx_start_low", txd, 1'b0);
        bus_wr(ADDR_DATA, 8'hFF);
        n = 0;
        while (txd === 1'b0 && n < 100) begin @(negedge clk); n++; end
        chk("tx_start_len", ((cyc - t0) >= 61 && (cyc - t0) <= 64), 1'b1);
        for (int k = 0; k < 9; k++) begin
            while (cyc < t0 + 64 * (k + 1) + 30) @(negedge clk);
            chk($sformatf("tx_bit%0d", k), txd, tx_q.pop_front());
        end
        wait_tbr(200);
        chk("tx_frame_len", ((cyc - t0) >= 630 && (cyc - t0) <= 645), 1'b1);
        hi = 1;
        repeat (700) begin @(negedge clk); if (txd !== 1'b1) hi = 0; end
        chk("tx_no_second", hi, 1);

        // Loopback receive
        loop = 1'b1;
        rx_q.push_back(8'hA3);
        bus_wr(ADDR_DATA, 8'hA3);
        wait_rda(1500);
        wait_tbr(200);
        rd_chk("lb_stat", ADDR_STAT, 8'h03);
        bus_rd(ADDR_DATA, d);
        chk("lb_data", d, rx_q.pop_front());
        chk("lb_rda_clr", rda, 1'b0);

        // Overrun: second frame overwrites the unread first
        bus_wr(ADDR_DATA, 8'h11);
        wait_tbr(800);
        rx_q.push_back(8'h22);
        bus_wr(ADDR_DATA, 8'h22);
        wait_tbr(800);
        repeat (10) @(negedge clk);
        rd_chk("oe_stat", ADDR_STAT, 8'h07);
        bus_rd(ADDR_DATA, d);
        chk("oe_data", d, rx_q.pop_front());
        rd_chk("oe_cleared", ADDR_STAT, 8'h01);

        // Framing error, glitch rejection, then a clean frame
        rxd_drv = 1'b1;
        loop = 1'b0;
        send_rx(8'h3C, 1'b0);
        repeat (100) @(negedge clk);
        chk("fe_rda", rda, 1'b0);
        rd_chk("fe_stat", ADDR_STAT, 8'h09);
        rd_chk("fe_cleared", ADDR_STAT, 8'h01);
        rxd_drv = 1'b0;
        repeat (8) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (700) @(negedge clk);
        rd_chk("glitch_stat", ADDR_STAT, 8'h01);
        rx_q.push_back(8'h96);
        send_rx(8'h96, 1'b1);
        wait_rda(200);
        bus_rd(ADDR_DATA, d);
        chk("rx_manual", d, rx_q.pop_front());

        // Reset in the middle of a zero byte
        bus_wr(ADDR_DATA, 8'h00);
        repeat (200) @(negedge clk);
        chk("mid_tx_low", txd, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_txd", txd, 1'b1);
        chk("mid_rst_tbr", tbr, 1'b1);
        rst = 1'b0;
        rd_chk("mid_rst_dbl", ADDR_DBL, 8'h16);

        chk("sb_empty", rd_q.size() + tx_q.size() + rx_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
